// File: rtl/obuf_drain_ctrl_if.sv
// obuf_drain_ctrl_if: bundle of the drain controller's command, bank-read and DDR-write signals
// Ports (master = controller view):
//   start, base_addr, num_words    command inputs
//   busy, done                     status outputs
//   bs_read_req, bs_read_addr      per-bank read request/address outputs
//   bs_read_data                   concatenated bank read data input
//   ddr_wdata, ddr_wvalid,
//   ddr_wlast, ddr_wready          DDR write channel
interface obuf_drain_ctrl_if #(
    parameter int NUM_BANKS       = 64,
    parameter int DATA_WIDTH      = 8,
    parameter int DDR_BANDWIDTH   = 512,
    parameter int READ_ADDR_WIDTH = 8,
    parameter int COUNT_WIDTH     = 16
);
    logic                                 start;
    logic [READ_ADDR_WIDTH-1:0]           base_addr;
    logic [COUNT_WIDTH-1:0]               num_words;
    logic                                 busy;
    logic                                 done;
    logic [NUM_BANKS-1:0]                 bs_read_req;
    logic [NUM_BANKS*READ_ADDR_WIDTH-1:0] bs_read_addr;
    logic [NUM_BANKS*DATA_WIDTH-1:0]      bs_read_data;
    logic [DDR_BANDWIDTH-1:0]             ddr_wdata;
    logic                                 ddr_wvalid;
    logic                                 ddr_wready;
    logic                                 ddr_wlast;

    modport master (
        input  start, base_addr, num_words, bs_read_data, ddr_wready,
        output busy, done, bs_read_req, bs_read_addr, ddr_wdata, ddr_wvalid, ddr_wlast
    );

    modport slave (
        output start, base_addr, num_words, bs_read_data, ddr_wready,
        input  busy, done, bs_read_req, bs_read_addr, ddr_wdata, ddr_wvalid, ddr_wlast
    );
endinterface

// File: rtl/obuf_drain_ctrl.sv
// obuf_drain_ctrl: drains a block of banked OBUF rows to the DDR write channel through a credit-limited FIFO
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    obuf_drain_ctrl_if.master: command/status, bank read port, DDR write channel
module obuf_drain_ctrl #(
    parameter int NUM_BANKS       = 64,
    parameter int DATA_WIDTH      = 8,
    parameter int DDR_BANDWIDTH   = 512,
    parameter int READ_ADDR_WIDTH = 8,
    parameter int READ_LATENCY_B  = 1,
    parameter int FIFO_DEPTH      = 4,
    parameter int COUNT_WIDTH     = 16
) (
    input logic clk,
    input logic reset,
    obuf_drain_ctrl_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                     state, state_n;
    logic [READ_ADDR_WIDTH-1:0] addr;
    logic [COUNT_WIDTH-1:0]     total, issued, sent;
    logic [READ_LATENCY_B-1:0]  vld_sr;
    logic [DDR_BANDWIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              fifo_count, inflight;
    logic                       accept, issue, push, pop, wvalid, wlast;

    // Credit rule: reads in flight plus words already buffered never exceed the FIFO depth
    assign issue  = state == READ && ({1'b0, inflight} + {1'b0, fifo_count} < (CW+1)'(FIFO_DEPTH));
    assign push   = vld_sr[READ_LATENCY_B-1];
    assign accept = state == IDLE && bus.start;
    assign wvalid = fifo_count != '0;
    assign wlast  = wvalid && sent == total - 1'b1;
    assign pop    = wvalid && bus.ddr_wready;

    assign bus.busy         = state != IDLE;
    assign bus.done         = state == DONE;
    assign bus.bs_read_req  = {NUM_BANKS{issue}};
    assign bus.bs_read_addr = {NUM_BANKS{addr}};
    assign bus.ddr_wvalid   = wvalid;
    assign bus.ddr_wlast    = wlast;
    assign bus.ddr_wdata    = wvalid ? mem[rd_ptr] : '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = bus.num_words == '0 ? DONE : READ;
            READ:    if (issue && issued == total - 1'b1) state_n = DRAIN;
            DRAIN:   if (pop && wlast) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // FIFO storage needs no reset: the read side is gated by fifo_count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.bs_read_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            total      <= '0;
            issued     <= '0;
            sent       <= '0;
            vld_sr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
        end else begin
            state      <= state_n;
            vld_sr     <= READ_LATENCY_B'({vld_sr, issue});
            inflight   <= inflight + CW'(issue) - CW'(push);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                sent   <= sent + 1'b1;
            end
            if (issue) begin
                addr   <= addr + 1'b1;
                issued <= issued + 1'b1;
            end
            if (accept) begin
                addr   <= bus.base_addr;
                total  <= bus.num_words;
                issued <= '0;
                sent   <= '0;
            end
        end
    end
endmodule
